bayer_demosaic_seq: RTL and testbench

BAYER_DEMOSAIC_SEQ -- requirements
Module: bayer_demosaic_seq

---
 rtl/bayer_demosaic_seq_pkg.sv | 13 +
 rtl/line_delay_ram.sv | 48 ++++
 rtl/bayer_demosaic_seq.sv | 148 ++++++++++++++
 tb/tb_bayer_demosaic_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_demosaic_seq_pkg.sv
// Shared types for the Bayer demosaic front end.
// Frame FSM encoding and default raw pixel width.
package bayer_demosaic_seq_pkg;

  localparam int DW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/line_delay_ram.sv
// One-line delay memory: simple dual-port, 1-cycle read.
// A read and a write to one address on one edge return the old word.
module line_delay_ram #(
  parameter int DW    = 10,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Read port holds its word unless a new read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read register; cleared on reset, contents of mem are not
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bayer_demosaic_seq.sv
// Raster sequencer feeding a 2x2 Bayer demosaic datapath.
// Tracks col/row, delays one line, emits pixel pairs with phase.
module bayer_demosaic_seq
  import bayer_demosaic_seq_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          FRAME_START,
  input  logic [1:0]    PATTERN,
  input  logic          IN_VALID,
  input  logic [DW-1:0] IN_DATA,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic          X,
  output logic          Y,
  output logic          DATA_EN,
  output logic          FRAME_DONE,
  output logic          ERR_SHORT
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    pat_q, pat_d;
  logic          err_q, err_d;
  logic [DW-1:0] d0_q, d0_d;
  logic          x_q, x_d;
  logic          y_q, y_d;
  logic          en_q, en_d;
  logic          accept;
  logic          emit;
  logic [DW-1:0] d1_w;

  // Frame FSM and raster counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pat_d   = pat_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (FRAME_START) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
          pat_d   = PATTERN;
        end
      end
      ACTIVE: begin
        if (FRAME_START) begin
          col_d = '0;
          row_d = '0;
          pat_d = PATTERN;
          err_d = 1'b1;
        end else if (IN_VALID) begin
          accept = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output beat: needs a left and an upper neighbour
  always_comb begin
    emit = accept && (row_q != '0) && (col_q != '0);
    d0_d = d0_q;
    x_d  = x_q;
    y_d  = y_q;
    en_d = emit;
    if (emit) begin
      d0_d = IN_DATA;
      x_d  = col_q[0] ^ pat_q[0];
      y_d  = row_q[0] ^ pat_q[1];
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      pat_q   <= '0;
      err_q   <= 1'b0;
      d0_q    <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      d0_q    <= d0_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
    end
  end

  line_delay_ram #(
    .DW    (DW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (accept),
    .waddr (col_q),
    .wdata (IN_DATA),
    .re    (emit),
    .raddr (col_q),
    .rdata (d1_w)
  );

  assign D0         = d0_q;
  assign D1         = d1_w;
  assign X          = x_q;
  assign Y          = y_q;
  assign DATA_EN    = en_q;
  assign FRAME_DONE = (state_q == DONE);
  assign ERR_SHORT  = err_q;

endmodule

// File: tb/tb_bayer_demosaic_seq.sv
// Bench for bayer_demosaic_seq at 4x3, DW=10.
// Constant vector table, corner sequences and a random run.
module tb_bayer_demosaic_seq;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          FRAME_START = 1'b0;
  logic [1:0]    PATTERN = 2'b00;
  logic          IN_VALID = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic [DW-1:0] D0, D1;
  logic          X, Y, DATA_EN, FRAME_DONE, ERR_SHORT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  bayer_demosaic_seq #(
    .DW    (DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FRAME_START (FRAME_START),
    .PATTERN     (PATTERN),
    .IN_VALID    (IN_VALID),
    .IN_DATA     (IN_DATA),
    .D0          (D0),
    .D1          (D1),
    .X           (X),
    .Y           (Y),
    .DATA_EN     (DATA_EN),
    .FRAME_DONE  (FRAME_DONE),
    .ERR_SHORT   (ERR_SHORT)
  );

  // Reference: frame as a pixel index n, col=n%W, row=n/W
  logic [DW-1:0] lb [W];
  bit            m_act;
  int            m_n;
  logic [1:0]    m_pat;
  logic [DW-1:0] m_d0, m_d1;
  logic          m_x, m_y, m_en, m_done, m_err;

  typedef struct {
    bit            fs;
    logic [1:0]    pat;
    bit            v;
    logic [DW-1:0] d;
    logic          en;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          x;
    logic          y;
    logic          done;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(bit fs, bit v, int d, bit en,
                              int d0, int d1, bit x, bit y,
                              bit done);
    vec_t r;
    r.fs = fs; r.pat = 2'b00; r.v = v;
    r.d = DW'(d); r.en = en;
    r.d0 = DW'(d0); r.d1 = DW'(d1);
    r.x = x; r.y = y; r.done = done;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(bit rst, bit fs, logic [1:0] pat,
                            bit v, logic [DW-1:0] d);
    int c, r;
    if (!rst) begin
      m_act = 0; m_n = 0; m_pat = 0;
      m_d0 = 0; m_d1 = 0; m_x = 0; m_y = 0;
      m_en = 0; m_done = 0; m_err = 0;
    end else begin
      m_en = 0;
      m_done = 0;
      if (fs) begin
        if (m_act) m_err = 1;
        m_act = 1; m_n = 0; m_pat = pat;
      end else if (m_act && v) begin
        c = m_n % W;
        r = m_n / W;
        if (r >= 1 && c >= 1) begin
          m_en = 1;
          m_d0 = d;
          m_d1 = lb[c];
          m_x = (c % 2 == 1) ^ m_pat[0];
          m_y = (r % 2 == 1) ^ m_pat[1];
        end
        lb[c] = d;
        m_n++;
        if (m_n == W * H) begin
          m_act = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic tick(bit rst, bit fs, logic [1:0] pat,
                      bit v, logic [DW-1:0] d);
    RST_N = rst; FRAME_START = fs; PATTERN = pat;
    IN_VALID = v; IN_DATA = d;
    @(posedge CLK);
    model_step(rst, fs, pat, v, d);
    @(negedge CLK);
    chk("m_en", DATA_EN, m_en);
    chk("m_done", FRAME_DONE, m_done);
    chk("m_err", ERR_SHORT, m_err);
    if (m_en) begin
      chk("m_d0", D0, m_d0);
      chk("m_d1", D1, m_d1);
      chk("m_x", X, m_x);
      chk("m_y", Y, m_y);
    end else begin
      chk("hold_d0", D0, m_d0);
      chk("hold_x", X, m_x);
      chk("hold_y", Y, m_y);
    end
  endtask

  logic [DW-1:0] got0 [$];
  logic [DW-1:0] got1 [$];
  logic          gx, gy;
  bit            seen;
  int            exp0 [6] = '{6, 7, 8, 10, 11, 12};
  int            exp1 [6] = '{2, 3, 4, 6, 7, 8};

  initial begin
    for (int i = 0; i < W; i++) lb[i] = '0;
    model_step(0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 0, 0,  0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1,  0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 2,  0, 0,  0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3,  0, 0,  0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 4,  0, 0,  0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 5,  0, 0,  0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 6,  1, 6,  2, 1, 1, 0);
    tbl[7]  = mk(0, 1, 7,  1, 7,  3, 0, 1, 0);
    tbl[8]  = mk(0, 1, 8,  1, 8,  4, 1, 1, 0);
    tbl[9]  = mk(0, 1, 9,  0, 8,  4, 1, 1, 0);
    tbl[10] = mk(0, 1, 10, 1, 10, 6, 1, 0, 0);
    tbl[11] = mk(0, 1, 11, 1, 11, 7, 0, 0, 0);
    tbl[12] = mk(0, 1, 12, 1, 12, 8, 1, 0, 1);
    tbl[13] = mk(0, 0, 0,  0, 12, 8, 1, 0, 0);
    tbl[14] = mk(0, 1, 77, 0, 12, 8, 1, 0, 0);

    // reset state
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_d0", D0, 0);
    chk("rst_d1", D1, 0);
    chk("rst_en", DATA_EN, 0);
    chk("rst_done", FRAME_DONE, 0);
    chk("rst_err", ERR_SHORT, 0);

    // basic frame from the constant table
    for (int i = 0; i < 15; i++) begin
      tick(1, tbl[i].fs, tbl[i].pat, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_en", i), DATA_EN, tbl[i].en);
      chk($sformatf("tbl%0d_d0", i), D0, tbl[i].d0);
      chk($sformatf("tbl%0d_d1", i), D1, tbl[i].d1);
      chk($sformatf("tbl%0d_x", i), X, tbl[i].x);
      chk($sformatf("tbl%0d_y", i), Y, tbl[i].y);
      chk($sformatf("tbl%0d_done", i), FRAME_DONE, tbl[i].done);
    end

    // gapped input, same beat sequence
    tick(1, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1, 0, 0, 1, DW'(k));
      if (DATA_EN) begin
        got0.push_back(D0);
        got1.push_back(D1);
      end
      tick(1, 0, 0, 0, DW'(500 + k));
      chk("gap_en_low", DATA_EN, 0);
    end
    chk("gap_beats", got0.size(), 6);
    for (int i = 0; i < 6 && i < got0.size(); i++) begin
      chk($sformatf("gap_d0_%0d", i), got0[i], exp0[i]);
      chk($sformatf("gap_d1_%0d", i), got1[i], exp1[i]);
    end

    // inverted phase
    seen = 0;
    tick(1, 1, 2'b11, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1, 0, 2'b00, 1, DW'(k));
      if (DATA_EN && !seen) begin
        seen = 1;
        chk("pat3_d0", D0, 6);
        chk("pat3_d1", D1, 2);
        chk("pat3_x", X, 0);
        chk("pat3_y", Y, 0);
      end
    end
    chk("pat3_seen", seen, 1);

    // short frame restart
    tick(1, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) tick(1, 0, 0, 1, DW'(k));
    tick(1, 1, 0, 1, DW'(99));
    chk("short_err", ERR_SHORT, 1);
    for (int k = 1; k <= 11; k++) begin
      tick(1, 0, 0, 1, DW'(20 + k));
      chk("short_nodone", FRAME_DONE, 0);
    end
    tick(1, 0, 0, 1, DW'(32));
    chk("short_done", FRAME_DONE, 1);
    tick(1, 0, 0, 0, 0);

    // reset mid-frame, then IDLE pulses
    tick(1, 1, 2'b01, 0, 0);
    for (int k = 1; k <= 5; k++) tick(1, 0, 0, 1, DW'(k));
    tick(0, 0, 0, 0, 0);
    chk("mrst_d0", D0, 0);
    chk("mrst_d1", D1, 0);
    chk("mrst_x", X, 0);
    chk("mrst_y", Y, 0);
    chk("mrst_err", ERR_SHORT, 0);
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 0, 1, DW'(900 + k));
      chk("idle_en", DATA_EN, 0);
      chk("idle_done", FRAME_DONE, 0);
    end
    tick(1, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) tick(1, 0, 0, 1, DW'(40 + k));
    chk("post_idle_done", FRAME_DONE, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 59) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
